keypad_scan: RTL

- Scanned 4x4 matrix keypad reader: the input-side counterpart of the multiplexed seven-segment output driver.
- Drives one column low at a time, samples the row lines, debounces whole scan frames and emits a 4-bit key code with a one-clock valid pulse.
- Sits between the board keypad pins and the clock/counter setting logic.
- Runs in the 50 MHz clk domain; the scan rate comes from a clock-enable, not a derived clock.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/key_scan_tick.sv | 53 +++++
 rtl/keypad_scan.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the scanned 4x4 keypad reader.
//   KEY_W         key code width, {row_idx[1:0], col_idx[1:0]}
//   frame_code_t  per-frame scan result: a NONE flag plus the key code
//   kp_state_e    debounce FSM state encoding
package keypad_pkg;

  localparam int KEY_W            = 4;
  localparam int SCAN_DIV_DEF     = 50000;  // 1 kHz column rate at 50 MHz
  localparam int DEBOUNCE_CNT_DEF = 4;

  // none=1 means zero keys or more than one key seen in the frame.
  typedef struct packed {
    logic             none;
    logic [KEY_W-1:0] key;
  } frame_code_t;

  localparam frame_code_t KEY_NONE = '{none: 1'b1, key: '0};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    PRESSED  = 2'd2,
    DB_REL   = 2'd3
  } kp_state_e;

endpackage

// File: rtl/key_scan_tick.sv
// key_scan_tick: scan timebase for the keypad reader.
//   clk, rst_n     clock, async active-low reset
//   tick_o         one-clk strobe at the last cycle of each column step
//   col_idx_o      index of the column currently driven
//   col_o          registered active-low column drive, one bit low
//   frame_end_o    tick of column 3 (last column of the frame)
module key_scan_tick
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick_o,
  output logic [1:0] col_idx_o,
  output logic [3:0] col_o,
  output logic       frame_end_o
);

  localparam int            TW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(SCAN_DIV - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    colo_q, colo_d;
  logic          tick;

  always_comb begin
    tick   = (tcnt_q == TMAX);
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    col_d  = tick ? col_q + 2'd1 : col_q;
    // Drive follows the next index so o_col changes on the same edge as col_idx.
    colo_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      col_q  <= 2'd0;
      colo_q <= 4'b1110;
    end else begin
      tcnt_q <= tcnt_d;
      col_q  <= col_d;
      colo_q <= colo_d;
    end
  end

  assign tick_o      = tick;
  assign col_idx_o   = col_q;
  assign col_o       = colo_q;
  assign frame_end_o = tick && (col_q == 2'd3);

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: scanned 4x4 matrix keypad reader with whole-frame debounce.
//   clk, rst_n     50 MHz clock, async active-low reset
//   i_row          active-low row lines (asynchronous, 2-flop synchronized)
//   o_col          active-low column drive, exactly one bit low
//   o_key          last accepted key {row_idx, col_idx}
//   o_key_valid    one-clk pulse on a newly accepted press
//   o_key_held     high while the accepted key stays pressed
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       i_row,
  output logic [3:0]       o_col,
  output logic [KEY_W-1:0] o_key,
  output logic             o_key_valid,
  output logic             o_key_held
);

  localparam int          CW     = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW:0] DB_TGT = (CW + 1)'(DEBOUNCE_CNT);

  logic       tick, frame_end;
  logic [1:0] col_idx;

  key_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_o     (tick),
    .col_idx_o  (col_idx),
    .col_o      (o_col),
    .frame_end_o(frame_end)
  );

  // Row synchronizer
  logic [3:0] row_s1_q, row_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= i_row;
      row_s2_q <= row_s1_q;
    end
  end

  // Frame accumulator: press count saturates at 2 ("more than one"),
  // first key is lowest column then lowest row thanks to scan order.
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [KEY_W-1:0] acc_key_q, acc_key_d;
  logic [3:0]       pressed;
  logic [1:0]       col_row;
  logic [2:0]       col_hits, hit_sum;
  logic [1:0]       tot;
  logic [KEY_W-1:0] first;
  frame_code_t      fc;

  always_comb begin
    pressed = ~row_s2_q;
    col_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (pressed[r]) col_row = 2'(r);
    end
    col_hits = {2'b0, pressed[0]} + {2'b0, pressed[1]}
             + {2'b0, pressed[2]} + {2'b0, pressed[3]};
    hit_sum  = {1'b0, acc_cnt_q} + col_hits;
    tot      = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    first    = (acc_cnt_q == 2'd0) ? {col_row, col_idx} : acc_key_q;

    acc_cnt_d = acc_cnt_q;
    acc_key_d = acc_key_q;
    if (tick) begin
      if (frame_end) begin
        acc_cnt_d = 2'd0;
        acc_key_d = '0;
      end else begin
        acc_cnt_d = tot;
        acc_key_d = first;
      end
    end

    fc = KEY_NONE;
    if (frame_end && tot == 2'd1) begin
      fc.none = 1'b0;
      fc.key  = first;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= 2'd0;
      acc_key_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      acc_key_q <= acc_key_d;
    end
  end

  // Debounce FSM, evaluated only at frame end. cnt is 0 on entry to IDLE and
  // PRESSED, so cnt_inc doubles as the "first frame" count there, which makes
  // DEBOUNCE_CNT=1 take the direct IDLE<->PRESSED path.
  kp_state_e        state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW:0]      cnt_inc;
  logic [KEY_W-1:0] key_q, key_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             same_key;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    valid_d  = 1'b0;
    held_d   = held_q;
    cnt_inc  = {1'b0, cnt_q} + 1'b1;
    same_key = !fc.none && (fc.key == key_q);

    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (!fc.none) begin
            cand_d = fc.key;
            if (cnt_inc == DB_TGT) begin
              state_d = PRESSED;
              key_d   = fc.key;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = DB_PRESS;
              cnt_d   = cnt_inc[CW-1:0];
            end
          end
        end
        DB_PRESS: begin
          if (!fc.none && fc.key == cand_q) begin
            if (cnt_inc == DB_TGT) begin
              state_d = PRESSED;
              key_d   = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc[CW-1:0];
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (!same_key) begin
            if (cnt_inc == DB_TGT) begin
              state_d = IDLE;
              held_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = DB_REL;
              cnt_d   = cnt_inc[CW-1:0];
            end
          end
        end
        DB_REL: begin
          if (!same_key) begin
            if (cnt_inc == DB_TGT) begin
              state_d = IDLE;
              held_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc[CW-1:0];
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign o_key       = key_q;
  assign o_key_valid = valid_q;
  assign o_key_held  = held_q;

endmodule
